trace_event_collector: RTL
==========================

Name: trace_event_collector

Overview:
- Synthesizable, parametrised trace collector for cpu_core debug. It merges NCH independent event channels (writeback, commit, redirect/recover, dispatch, ...) into one timestamped, channel-tagged FIFO stream.
- A host-side drain (UART/JTAG/bench) consumes the stream.
- Adds commit counting, commit-limit stop, no-commit watchdog, lossy/backpressure modes and per-channel drop accounting.

Parameters:
- NCH, 4, number of event channels (2..8).
- DATA_W, 64, payload bits per event.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CYC_W, 32, timestamp and cycle-counter width.
- COMMIT_CH, 1, index of the channel whose events count as commits.
- COMMIT_LIMIT, 50000, commit count that sets limit_hit; 0 disables.
- WDOG_CYCLES, 5000, cycles without a commit before the watchdog fires; 0 disables.
- LOSSY, 0, mode select: 0 = backpressure producers; 1 = never stall, drop and count instead.
- DROP_W, 16, width of each per-channel drop counter.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- trace_en, in, 1, when 0 events are accepted and discarded (not enqueued, not counted as drops).
- ev_valid, in, NCH, per-channel event valid.
- ev_ready, out, NCH, per-channel accept.
- ev_data, in, NCH*DATA_W, payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- out_valid, out, 1, FIFO head valid.
- out_ready, in, 1, consumer accept.
- out_chan, out, $clog2(NCH), channel of head entry.
- out_cycle, out, CYC_W, cycle stamp of head entry.
- out_data, out, DATA_W, payload of head entry.
- drop_cnt, out, NCH*DROP_W, per-channel saturating drop counters.
- commit_count, out, 32, accepted commit-channel events (saturating).
- wdog_fire, out, 1, single-cycle pulse when the watchdog expires.
- done, out, 1, sticky; set by limit_hit or watchdog trip.

Behaviour:
- Reset, synchronous while rst_n=0 at posedge:
  - cycle counter, FIFO pointers/count, RR pointer, drop_cnt, commit_count, watchdog counter, wdog_fire, done all 0.
  - out_valid=0. ev_ready=0 during reset.
  - Reset mid-operation discards all FIFO contents.
- Cycle counter: +1 every cycle out of reset; wraps modulo 2^CYC_W.
- Event enqueue:
  - Arbitration: at most one event is enqueued per cycle. Grant goes round-robin among valid channels, searching from (last_grant+1) mod NCH; pointer resets to 0.
  - Stamp: the enqueued entry carries {chan, cycle_counter value in the accept cycle, data}.
- LOSSY=0, backpressure mode:
  - ev_ready[i]=1 only for the granted channel, and only when FIFO not full.
  - Other channels hold valid and retry.
  - Full is based on registered count only; a same-cycle pop does not enable a push.
- LOSSY=1, lossy mode:
  - ev_ready = all ones.
  - Granted channel is enqueued if FIFO not full, otherwise dropped.
  - Every valid, non-enqueued channel that cycle increments its drop_cnt, saturating at 2^DROP_W-1.
- trace_en=0: ev_ready = all ones, nothing enqueued, drop_cnt unchanged, commit counting continues.
- Dequeue:
  - Pop on out_valid && out_ready.
  - Head fields are stable while out_valid=1 and out_ready=0.
  - Latency: event accepted at edge N appears at the head no earlier than the cycle after edge N (registered FIFO, no bypass).
- Simultaneous push and pop with count < DEPTH: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
- Commit tracking:
  - commit event = ev_valid[COMMIT_CH] && ev_ready[COMMIT_CH], regardless of enqueue or drop.
  - commit_count increments on each commit event, saturating at 2^32-1.
  - limit_hit = commit_count reaches COMMIT_LIMIT (COMMIT_LIMIT != 0).
- Watchdog:
  - Counter clears on a commit event, else increments, saturating.
  - When it reaches WDOG_CYCLES (WDOG_CYCLES != 0): wdog_fire is high for exactly one cycle and the watchdog is tripped. It does not re-fire until reset.
- done: sticky; set the cycle after limit_hit or watchdog trip. Collection continues after done; only rst_n clears it.

Test Plan:
- Reset, then single event ch2 data=0xAB at cycle 7 → one output {chan=2, cycle=7, data=0xAB} next cycle; drop_cnt all 0.
- LOSSY=0, all 4 channels valid continuously, out_ready=1 → grants 0,1,2,3,0,...; each channel ev_ready exactly one cycle in four; no loss.
- LOSSY=0, DEPTH=16, out_ready=0, 20 events offered → 16 accepted, then ev_ready=0; raising out_ready drains 16 in order with increasing cycle stamps.
- LOSSY=1, FIFO full, ch0 and ch3 valid 5 cycles → drop_cnt[0]=5, drop_cnt[3]=5, ev_ready stays 1.
- COMMIT_LIMIT=10, 10 commit events on COMMIT_CH → commit_count=10, done=1 the following cycle.
- WDOG_CYCLES=8, one commit then silence → wdog_fire pulses once 8 cycles later, done stays 1; reset mid-run clears done, FIFO and counters.

Source files
------------

// File: rtl/trace_event_collector.sv
// trace_event_collector
//   Merges NCH event channels into one timestamped, channel-tagged FIFO
//   stream for a host-side drain. Also counts commits, raises done on a
//   commit limit or a no-commit watchdog trip, and in lossy mode counts
//   per-channel drops instead of stalling producers.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   trace_en              0: events are accepted and discarded
//   ev_valid/ev_ready     per-channel handshake (NCH bits)
//   ev_data               channel i payload at [i*DATA_W +: DATA_W]
//   out_valid/out_ready   FIFO head handshake
//   out_chan/cycle/data   fields of the FIFO head entry
//   drop_cnt              per-channel saturating drop counters
//   commit_count          saturating count of accepted commit-channel events
//   wdog_fire             one-cycle pulse when the watchdog expires
//   done                  sticky: commit limit reached or watchdog tripped
module trace_event_collector #(
  parameter int NCH          = 4,
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 32,
  parameter int COMMIT_CH    = 1,
  parameter int COMMIT_LIMIT = 50000,
  parameter int WDOG_CYCLES  = 5000,
  parameter int LOSSY        = 0,
  parameter int DROP_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trace_en,
  input  logic [NCH-1:0]            ev_valid,
  output logic [NCH-1:0]            ev_ready,
  input  logic [NCH*DATA_W-1:0]     ev_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NCH)-1:0]    out_chan,
  output logic [CYC_W-1:0]          out_cycle,
  output logic [DATA_W-1:0]         out_data,
  output logic [NCH*DROP_W-1:0]     drop_cnt,
  output logic [31:0]               commit_count,
  output logic                      wdog_fire,
  output logic                      done
);

  localparam int CH_W = $clog2(NCH);
  localparam int AW   = $clog2(DEPTH);

  function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + DROP_W'(1);
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [CYC_W-1:0]  cyc_q;
  logic [CH_W-1:0]   rr_q;
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;
  logic [DROP_W-1:0] drop_q [NCH];
  logic [31:0]       commit_q;
  logic [31:0]       wd_q;
  logic              wd_trip_q;
  logic              fire_q;
  logic              done_q;

  logic [CH_W-1:0]   chan_mem [DEPTH];
  logic [CYC_W-1:0]  cyc_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              full;
  logic              pop;
  logic              gnt_any;
  logic [CH_W-1:0]   gnt;
  logic [CH_W-1:0]   rr_nxt;
  logic              rr_adv;
  int                idx;
  logic              commit_ev;
  logic              limit_hit;
  logic [31:0]       wd_nxt;
  logic              wd_hit;

  // accept stage (p0): arbitration, handshake and entry formation
  logic              push_vld_p0;
  logic [DATA_W-1:0] ent_data_p0;

  assign full = (cnt_q == (AW+1)'(DEPTH));

  // Round-robin: the first valid channel at or after rr_q wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = '0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_q) + k) % NCH;
      if (!gnt_any && ev_valid[idx]) begin
        gnt_any = 1'b1;
        gnt     = CH_W'(idx);
      end
    end
  end

  assign rr_nxt = CH_W'((int'(gnt) + 1) % NCH);

  always_comb begin
    ev_ready = '0;
    if (!rst_n)
      ev_ready = '0;
    else if (!trace_en || LOSSY != 0)
      ev_ready = '1;
    else if (gnt_any && !full)
      ev_ready[gnt] = 1'b1;
  end

  // Full is judged on the registered count only; a same-cycle pop never
  // makes room for a push.
  assign push_vld_p0 = rst_n && trace_en && gnt_any && !full;
  // In lossy mode a grant lost to a full FIFO still moves the pointer on,
  // so one channel cannot monopolise the slot after the FIFO drains.
  assign rr_adv      = rst_n && trace_en && gnt_any && (LOSSY != 0 || !full);
  assign ent_data_p0 = ev_data[gnt*DATA_W +: DATA_W];

  assign commit_ev = ev_valid[COMMIT_CH] && ev_ready[COMMIT_CH];
  assign limit_hit = (COMMIT_LIMIT != 0) && (commit_q >= 32'(COMMIT_LIMIT));
  assign wd_nxt    = commit_ev ? 32'd0 : sat_inc32(wd_q);
  assign wd_hit    = (WDOG_CYCLES != 0) && !wd_trip_q && (wd_nxt == 32'(WDOG_CYCLES));

  assign pop = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q     <= '0;
      rr_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      commit_q  <= '0;
      wd_q      <= '0;
      wd_trip_q <= 1'b0;
      fire_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) drop_q[i] <= '0;
    end else begin
      cyc_q <= cyc_q + CYC_W'(1);
      if (rr_adv) rr_q <= rr_nxt;
      if (push_vld_p0) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      if (push_vld_p0 && !pop)
        cnt_q <= cnt_q + (AW+1)'(1);
      else if (!push_vld_p0 && pop)
        cnt_q <= cnt_q - (AW+1)'(1);
      if (commit_ev) commit_q <= sat_inc32(commit_q);
      wd_q      <= wd_nxt;
      fire_q    <= wd_hit;
      wd_trip_q <= wd_trip_q | wd_hit;
      done_q    <= done_q | limit_hit | fire_q;
      for (int i = 0; i < NCH; i++) begin
        if (LOSSY != 0 && trace_en && ev_valid[i] &&
            !(push_vld_p0 && gnt == CH_W'(i)))
          drop_q[i] <= sat_inc_drop(drop_q[i]);
      end
    end
  end

  // storage stage (p1): entries become visible at the head one cycle after
  // acceptance; payload storage carries no reset
  always_ff @(posedge clk) begin
    if (push_vld_p0) begin
      chan_mem[wr_q] <= gnt;
      cyc_mem[wr_q]  <= cyc_q;
      data_mem[wr_q] <= ent_data_p0;
    end
  end

  assign out_valid    = (cnt_q != '0);
  assign out_chan     = chan_mem[rd_q];
  assign out_cycle    = cyc_mem[rd_q];
  assign out_data     = data_mem[rd_q];
  assign commit_count = commit_q;
  assign wdog_fire    = fire_q;
  assign done         = done_q;

  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < NCH; i++) drop_cnt[i*DROP_W +: DROP_W] = drop_q[i];
  end

endmodule
